// File: rtl/diag_mem_bridge.sv
// SPI-byte-driven CPU halt and ranged RAM read/write engine for ROMulator diagnostics.
// Each received SPI byte advances exactly one step; ranged transfers end with an 8-bit checksum.
module diag_mem_bridge #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned CFG_W     = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned HALT_WAIT = 8
) (
  input  logic              fpga_clk,
  input  logic              fpga_reset,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              spi_select,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  output logic              halt,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              we,
  output logic              cs,
  input  logic [CFG_W-1:0]  configuration
);

  localparam int unsigned NB   = ADDR_W / 8;
  localparam int unsigned HW_W = $clog2(HALT_WAIT + 2);
  localparam int unsigned LT_W = $clog2(RD_LAT + 1);
  localparam int unsigned HC_W = $clog2(2 * NB + 1);

  localparam logic [7:0] CMD_HALT   = 8'hAA;
  localparam logic [7:0] CMD_RESUME = 8'h55;
  localparam logic [7:0] CMD_CFG    = 8'h77;
  localparam logic [7:0] CMD_READ   = 8'h66;
  localparam logic [7:0] CMD_WRITE  = 8'h99;

  typedef enum logic [3:0] {
    ST_STARTUP,
    ST_RUNNING,
    ST_CFG_TX,
    ST_HALTED,
    ST_HDR,
    ST_RD_ADDR,
    ST_RD_TX,
    ST_RD_NEXT,
    ST_WR_RX,
    ST_WR_STROBE,
    ST_WR_NEXT,
    ST_SUM_TX,
    ST_SUM_ACK
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] len;
  logic [7:0]        sum;
  logic [CFG_W-1:0]  cfg_q;
  logic [HW_W-1:0]   settle;
  logic [LT_W-1:0]   lat_cnt;
  logic [HC_W-1:0]   hdr_cnt;
  logic              op_wr;
  logic              sel_q;
  logic              in_frame;
  logic              abort;

  always_comb begin
    in_frame = 1'b0;
    case (state)
      ST_HDR, ST_RD_ADDR, ST_RD_TX, ST_RD_NEXT,
      ST_WR_RX, ST_WR_STROBE, ST_WR_NEXT,
      ST_SUM_TX, ST_SUM_ACK: in_frame = 1'b1;
      default: in_frame = 1'b0;
    endcase
  end

  // Chip-select rising edge ends the frame; checked before rx_dv so it always wins.
  assign abort = in_frame & spi_select & ~sel_q;

  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      state    <= ST_STARTUP;
      tx_dv    <= 1'b0;
      tx_byte  <= '0;
      halt     <= 1'b0;
      address  <= '0;
      data_out <= '0;
      we       <= 1'b0;
      cs       <= 1'b0;
      len      <= '0;
      sum      <= '0;
      cfg_q    <= '0;
      settle   <= '0;
      lat_cnt  <= '0;
      hdr_cnt  <= '0;
      op_wr    <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      sel_q <= spi_select;
      tx_dv <= 1'b0;
      we    <= 1'b0;
      if (settle != '0) settle <= settle - HW_W'(1);

      if (abort) begin
        cs    <= 1'b0;
        state <= ST_HALTED;
      end else begin
        case (state)
          ST_STARTUP: begin
            cfg_q <= configuration;
            state <= ST_RUNNING;
          end

          ST_RUNNING: begin
            if (rx_dv) begin
              if (rx_byte == CMD_HALT) begin
                halt   <= 1'b1;
                settle <= HW_W'(HALT_WAIT);
                state  <= ST_HALTED;
              end else if (rx_byte == CMD_CFG) begin
                tx_dv   <= 1'b1;
                tx_byte <= 8'(cfg_q);
                state   <= ST_CFG_TX;
              end
            end
          end

          // The config read is legal while halted, so go back to wherever it came from.
          ST_CFG_TX: begin
            if (rx_dv) state <= halt ? ST_HALTED : ST_RUNNING;
          end

          ST_HALTED: begin
            if (rx_dv) begin
              if (rx_byte == CMD_RESUME) begin
                halt  <= 1'b0;
                state <= ST_RUNNING;
              end else if (rx_byte == CMD_CFG) begin
                tx_dv   <= 1'b1;
                tx_byte <= 8'(cfg_q);
                state   <= ST_CFG_TX;
              end else if ((rx_byte == CMD_READ || rx_byte == CMD_WRITE) && settle == '0) begin
                op_wr    <= (rx_byte == CMD_WRITE);
                hdr_cnt  <= '0;
                sum      <= '0;
                data_out <= '0;
                state    <= ST_HDR;
              end
            end
          end

          ST_HDR: begin
            if (rx_dv) begin
              if (hdr_cnt < HC_W'(NB)) address <= (address << 8) | ADDR_W'(rx_byte);
              else                     len     <= (len << 8) | ADDR_W'(rx_byte);
              hdr_cnt <= hdr_cnt + HC_W'(1);
              if (hdr_cnt == HC_W'(2 * NB - 1)) begin
                cs      <= 1'b1;
                lat_cnt <= '0;
                state   <= op_wr ? ST_WR_RX : ST_RD_ADDR;
              end
            end
          end

          ST_RD_ADDR: begin
            if (lat_cnt == LT_W'(RD_LAT - 1)) begin
              tx_dv   <= 1'b1;
              tx_byte <= data_in;
              sum     <= sum + data_in;
              state   <= ST_RD_TX;
            end else begin
              lat_cnt <= lat_cnt + LT_W'(1);
            end
          end

          // Length 0 wraps to all-ones on the first decrement, giving the full map.
          ST_RD_TX, ST_RD_NEXT: begin
            if (rx_dv) begin
              address <= address + ADDR_W'(1);
              len     <= len - ADDR_W'(1);
              if (len == ADDR_W'(1)) begin
                tx_dv   <= 1'b1;
                tx_byte <= sum;
                cs      <= 1'b0;
                state   <= ST_SUM_TX;
              end else begin
                lat_cnt <= '0;
                state   <= ST_RD_ADDR;
              end
            end else begin
              state <= ST_RD_NEXT;
            end
          end

          // data_out still holds the previous byte, which is what gets echoed back.
          ST_WR_RX: begin
            if (rx_dv) begin
              tx_dv    <= 1'b1;
              tx_byte  <= data_out;
              data_out <= rx_byte;
              sum      <= sum + rx_byte;
              we       <= 1'b1;
              state    <= ST_WR_STROBE;
            end
          end

          ST_WR_STROBE: state <= ST_WR_NEXT;

          ST_WR_NEXT: begin
            address <= address + ADDR_W'(1);
            len     <= len - ADDR_W'(1);
            if (len == ADDR_W'(1)) begin
              tx_dv   <= 1'b1;
              tx_byte <= sum;
              cs      <= 1'b0;
              state   <= ST_SUM_TX;
            end else begin
              state <= ST_WR_RX;
            end
          end

          ST_SUM_TX, ST_SUM_ACK: begin
            state <= rx_dv ? ST_HALTED : ST_SUM_ACK;
          end

          default: state <= ST_STARTUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diag_mem_bridge.sv
// Bench for diag_mem_bridge: a 16-bit instance for directed/random traffic and an 8-bit,
// RD_LAT=3 instance for the full-map read, sharing one RAM image and one SPI driver.
module tb_diag_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_dv, spi_select;
  logic [7:0] rx_byte;
  logic [3:0] cfg;
  bit         sel;

  logic        rx_dv_m, tx_dv_m, halt_m, we_m, cs_m;
  logic [7:0]  tx_byte_m, data_in_m, data_out_m;
  logic [15:0] address_m;
  logic        rx_dv_f, tx_dv_f, halt_f, we_f, cs_f;
  logic [7:0]  tx_byte_f, data_in_f, data_out_f;
  logic [7:0]  address_f;

  assign rx_dv_m = rx_dv & ~sel;
  assign rx_dv_f = rx_dv & sel;

  diag_mem_bridge #(.ADDR_W(16), .CFG_W(4), .RD_LAT(2), .HALT_WAIT(8)) u_main (
    .fpga_clk(clk), .fpga_reset(rst_n), .rx_dv(rx_dv_m), .rx_byte(rx_byte),
    .spi_select(spi_select), .tx_dv(tx_dv_m), .tx_byte(tx_byte_m), .halt(halt_m),
    .address(address_m), .data_in(data_in_m), .data_out(data_out_m), .we(we_m),
    .cs(cs_m), .configuration(cfg));

  diag_mem_bridge #(.ADDR_W(8), .CFG_W(4), .RD_LAT(3), .HALT_WAIT(8)) u_full (
    .fpga_clk(clk), .fpga_reset(rst_n), .rx_dv(rx_dv_f), .rx_byte(rx_byte),
    .spi_select(spi_select), .tx_dv(tx_dv_f), .tx_byte(tx_byte_f), .halt(halt_f),
    .address(address_f), .data_in(data_in_f), .data_out(data_out_f), .we(we_f),
    .cs(cs_f), .configuration(cfg));

  // RAM image with read latency modelled as (RD_LAT-1) address register stages
  logic [7:0]  mem [65536];
  logic [7:0]  model_mem [65536];
  logic [15:0] am_q;
  logic [7:0]  af_q1, af_q2;

  always @(posedge clk) begin
    am_q  <= address_m;
    af_q1 <= address_f;
    af_q2 <= af_q1;
    if (we_m && cs_m) mem[address_m] = data_out_m;
    if (we_f && cs_f) mem[{8'h00, address_f}] = data_out_f;
  end
  assign data_in_m = mem[am_q];
  assign data_in_f = mem[{8'h00, af_q2}];

  logic        tx_dv_s, cs_s, halt_s, we_s;
  logic [7:0]  tx_byte_s;
  logic [15:0] address_s;
  assign tx_dv_s   = sel ? tx_dv_f   : tx_dv_m;
  assign tx_byte_s = sel ? tx_byte_f : tx_byte_m;
  assign address_s = sel ? {8'h00, address_f} : address_m;
  assign cs_s      = sel ? cs_f      : cs_m;
  assign halt_s    = sel ? halt_f    : halt_m;
  assign we_s      = sel ? we_f      : we_m;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  logic [7:0]  txq[$];
  logic [15:0] adq[$];

  always @(negedge clk) begin
    if (tx_dv_s) begin
      txq.push_back(tx_byte_s);
      adq.push_back(address_s);
    end
    if (we_s) begin
      we_cnt++;
      chk("we_requires_cs", cs_s, 1);
    end
  end

  logic [7:0]  wdata   [256];
  logic [7:0]  got     [256];
  logic [15:0] gaddr   [256];
  logic [7:0]  exp_tx  [256];
  logic [15:0] exp_addr[256];
  logic [7:0]  got_sum, exp_sum;
  bit          op_ok;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx(output logic [7:0] b, output logic [15:0] a, output bit ok);
    ok = 1'b0;
    b  = '0;
    a  = '0;
    for (int i = 0; i < 40; i++) begin
      if (txq.size() > 0) break;
      @(negedge clk);
    end
    if (txq.size() > 0) begin
      b  = txq.pop_front();
      a  = adq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic send_header(input bit wr, input int unsigned a, input int unsigned n,
                             input int unsigned nb);
    send_byte(wr ? 8'h99 : 8'h66);
    for (int i = int'(nb) - 1; i >= 0; i--) send_byte(8'(a >> (8 * i)));
    for (int i = int'(nb) - 1; i >= 0; i--) send_byte(8'(n >> (8 * i)));
  endtask

  task automatic run_op(input bit wr, input int unsigned a, input int unsigned n,
                        input int unsigned nb);
    int unsigned total;
    logic [7:0]  b;
    logic [15:0] ad;
    bit          ok;
    txq.delete();
    adq.delete();
    op_ok = 1'b1;
    total = (n == 0) ? (32'd1 << (8 * nb)) : n;
    send_header(wr, a, n, nb);
    for (int unsigned i = 0; i < total; i++) begin
      if (wr) send_byte(wdata[i]);
      wait_tx(b, ad, ok);
      if (!ok) begin
        op_ok = 1'b0;
        chk("tx_timeout", 0, 1);
        return;
      end
      got[i]   = b;
      gaddr[i] = ad;
      if (!wr) send_byte(8'h00);
    end
    wait_tx(b, ad, ok);
    if (!ok) begin
      op_ok = 1'b0;
      chk("sum_timeout", 0, 1);
      return;
    end
    got_sum = b;
    send_byte(8'h00);
  endtask

  // Reference: byte i lives at (start+i) mod 2^W; write echoes the previous byte, first 00.
  task automatic model_op(input bit wr, input int unsigned a, input int unsigned total,
                          input int unsigned mask);
    logic [7:0] prev = 8'h00;
    logic [7:0] s    = 8'h00;
    for (int unsigned i = 0; i < total; i++) begin
      int unsigned ad;
      ad          = (a + i) & mask;
      exp_addr[i] = 16'(ad);
      if (wr) begin
        exp_tx[i]      = prev;
        prev           = wdata[i];
        model_mem[ad]  = wdata[i];
        s              = s + wdata[i];
      end else begin
        exp_tx[i] = model_mem[ad];
        s         = s + model_mem[ad];
      end
    end
    exp_sum = s;
  endtask

  task automatic verify_op(input string tag, input bit wr, input int unsigned total);
    int nbad = 0;
    int mbad = 0;
    if (!op_ok) return;
    if (total <= 16) begin
      for (int unsigned i = 0; i < total; i++) begin
        chk($sformatf("%s_tx%0d", tag, i), got[i], exp_tx[i]);
        chk($sformatf("%s_addr%0d", tag, i), gaddr[i], exp_addr[i]);
      end
    end else begin
      for (int unsigned i = 0; i < total; i++)
        if (got[i] !== exp_tx[i] || gaddr[i] !== exp_addr[i]) nbad++;
      chk($sformatf("%s_bad_bytes", tag), nbad, 0);
    end
    chk($sformatf("%s_sum", tag), got_sum, exp_sum);
    if (wr) begin
      for (int unsigned i = 0; i < total; i++)
        if (mem[exp_addr[i]] !== model_mem[exp_addr[i]]) mbad++;
      chk($sformatf("%s_ram", tag), mbad, 0);
    end
  endtask

  typedef struct {
    bit              wr;
    logic [15:0]     addr;
    logic [15:0]     len;
    logic [2:0][7:0] data;
    logic [2:0][7:0] exp_tx;
    logic [7:0]      exp_sum;
    int              exp_we;
  } vec_t;

  vec_t vt[5];

  task automatic set_vec(input int k, input bit wr, input logic [15:0] a, input logic [15:0] n,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] s);
    vt[k].wr      = wr;
    vt[k].addr    = a;
    vt[k].len     = n;
    vt[k].data    = {d2, d1, d0};
    vt[k].exp_tx  = {e2, e1, e0};
    vt[k].exp_sum = s;
    vt[k].exp_we  = wr ? int'(n) : 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    logic [15:0] ad;
    bit          ok;
    int          we0;

    set_vec(0, 0, 16'h0010, 16'h0003, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06);
    set_vec(1, 1, 16'hFFFF, 16'h0002, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h5A, 8'h00, 8'hFF);
    set_vec(2, 0, 16'hFFFF, 16'h0002, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'hFF);
    set_vec(3, 1, 16'h1234, 16'h0003, 8'h10, 8'h20, 8'h30, 8'h00, 8'h10, 8'h20, 8'h60);
    set_vec(4, 0, 16'h1234, 16'h0003, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h60);

    for (int i = 0; i < 65536; i++) begin
      mem[i]       = 8'($urandom);
      model_mem[i] = mem[i];
    end
    for (int i = 0; i < 3; i++) begin
      mem[16 + i]       = 8'(i + 1);
      model_mem[16 + i] = 8'(i + 1);
    end

    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = '0; spi_select = 1'b0; cfg = 4'hA; sel = 1'b0;
    tick(3);
    chk("reset_outputs", {halt_m, cs_m, tx_dv_m, we_m, address_m, tx_byte_m, data_out_m}, 0);
    rst_n = 1'b1;
    tick(3);

    // configuration read from RUNNING
    txq.delete(); adq.delete();
    send_byte(8'h77);
    wait_tx(b, ad, ok);
    chk("cfg_seen", ok, 1);
    chk("cfg_byte", b, 8'h0A);
    send_byte(8'h00);
    chk("halt_after_cfg", halt_m, 0);

    // halt, then an early read command that must be swallowed
    send_byte(8'hAA);
    chk("halt_set", halt_m, 1);
    send_byte(8'h66);
    chk("early_cmd_cs", cs_m, 0);
    chk("early_cmd_tx", txq.size(), 0);
    tick(10);

    for (int k = 0; k < 5; k++) begin
      int unsigned n;
      n   = vt[k].len;
      we0 = we_cnt;
      for (int unsigned i = 0; i < n; i++) wdata[i] = vt[k].data[i];
      model_op(vt[k].wr, vt[k].addr, n, 32'hFFFF);
      run_op(vt[k].wr, vt[k].addr, n, 2);
      if (op_ok) begin
        for (int unsigned i = 0; i < n; i++)
          chk($sformatf("vec%0d_tx%0d", k, i), got[i], vt[k].exp_tx[i]);
        chk($sformatf("vec%0d_sum", k), got_sum, vt[k].exp_sum);
      end
      chk($sformatf("vec%0d_we_pulses", k), we_cnt - we0, vt[k].exp_we);
      chk($sformatf("vec%0d_cs_idle", k), cs_m, 0);
    end
    chk("wrap_ram_ffff", mem[16'hFFFF], 8'h5A);
    chk("wrap_ram_0000", mem[16'h0000], 8'hA5);

    for (int r = 0; r < 8; r++) begin
      bit          wr;
      int unsigned a, n;
      wr = 1'($urandom);
      a  = $urandom_range(0, 65535);
      n  = $urandom_range(1, 6);
      for (int unsigned i = 0; i < n; i++) wdata[i] = 8'($urandom);
      model_op(wr, a, n, 32'hFFFF);
      run_op(wr, a, n, 2);
      verify_op($sformatf("rnd%0d", r), wr, n);
    end

    // abort a 16-byte write after 4 bytes
    for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
    txq.delete(); adq.delete();
    we0 = we_cnt;
    send_header(1, 32'h0200, 32'h0010, 2);
    for (int i = 0; i < 4; i++) send_byte(wdata[i]);
    tick(2);
    spi_select = 1'b1;
    tick(3);
    chk("abort_cs", cs_m, 0);
    chk("abort_halt", halt_m, 1);
    chk("abort_we_pulses", we_cnt - we0, 4);
    chk("abort_no_sum", txq.size(), 4);
    for (int i = 0; i < 4; i++) model_mem[16'h0200 + i] = wdata[i];
    spi_select = 1'b0;
    tick(2);
    model_op(0, 32'h0200, 5, 32'hFFFF);
    run_op(0, 32'h0200, 5, 2);
    verify_op("post_abort_rd", 0, 5);
    send_byte(8'h55);
    chk("resume_halt", halt_m, 0);

    // full-map read on the 8-bit, RD_LAT=3 instance
    sel = 1'b1;
    send_byte(8'hAA);
    chk("full_halt", halt_f, 1);
    tick(12);
    model_op(0, 32'h40, 256, 32'hFF);
    run_op(0, 32'h40, 0, 1);
    verify_op("fullmap", 0, 256);
    chk("fullmap_cs_idle", cs_f, 0);
    send_byte(8'h55);
    sel = 1'b0;

    // asynchronous reset in the middle of a read
    send_byte(8'hAA);
    tick(10);
    txq.delete(); adq.delete();
    send_header(0, 32'h0020, 32'h0003, 2);
    wait_tx(b, ad, ok);
    chk("midread_first_byte_seen", ok, 1);
    chk("midread_cs", cs_m, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           {halt_m, cs_m, tx_dv_m, we_m, address_m, tx_byte_m, data_out_m}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    send_byte(8'hAA);
    chk("halt_after_reset", halt_m, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
